// File: rtl/jtag_seq_pkg.sv
// Shared phase encoding and constants for the JTAG scan sequencer.
package jtag_seq_pkg;

    typedef enum logic [3:0] {
        PH_TLR,
        PH_RTI,
        PH_LAUNCH,
        PH_SEL_DR,
        PH_SEL_IR,
        PH_CAP,
        PH_SHIFT,
        PH_EXIT1,
        PH_UPD
    } phase_e;

    localparam int unsigned TLR_ONES = 5;

endpackage

// File: rtl/jtag_shift_reg.sv
// Scan data register: parallel load, shift right with serial input at the MSB.
module jtag_shift_reg #(
    parameter int MAX_LEN = 32
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               load_i,
    input  logic [MAX_LEN-1:0] load_data_i,
    input  logic               shift_i,
    input  logic               sin_i,
    output logic [MAX_LEN-1:0] q_o,
    output logic               sout_o
);

    logic [MAX_LEN-1:0] sreg_q, sreg_d;

    always_comb begin
        sreg_d = sreg_q;
        if (load_i) begin
            sreg_d = load_data_i;
        end else if (shift_i) begin
            sreg_d = {sin_i, sreg_q[MAX_LEN-1:1]};
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sreg_q <= '0;
        end else begin
            sreg_q <= sreg_d;
        end
    end

    assign q_o    = sreg_q;
    assign sout_o = sreg_q[0];

endmodule

// File: rtl/jtag_scan_sequencer.sv
// Turns host scan commands into TMS/TDI walks for a 1149.1 TAP, mirroring the TAP state.
module jtag_scan_sequencer
    import jtag_seq_pkg::*;
#(
    parameter int MAX_LEN = 32,
    parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic               tck,
    input  logic               trst,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic               cmd_rst,
    input  logic               cmd_ir,
    input  logic [LEN_W-1:0]   cmd_len,
    input  logic [MAX_LEN-1:0] cmd_data,
    output logic               rsp_valid,
    output logic [MAX_LEN-1:0] rsp_data,
    output logic               busy,
    output logic               tms,
    output logic               tdi,
    input  logic               tdo
);

    localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);

    phase_e             phase_q, phase_d;
    logic [LEN_W-1:0]   cnt_q, cnt_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic               ir_q, ir_d;
    logic               rst_cmd_q, rst_cmd_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [MAX_LEN-1:0] rsp_data_q, rsp_data_d;

    logic               accept, load, shift_en, last_shift;
    logic [LEN_W-1:0]   len_clamp;
    logic [MAX_LEN-1:0] sreg, all_ones, aligned, mask;
    logic               sreg_out;

    jtag_shift_reg #(.MAX_LEN(MAX_LEN)) u_sreg (
        .clk_i       (tck),
        .rst_i       (trst),
        .load_i      (load),
        .load_data_i (cmd_data),
        .shift_i     (shift_en),
        .sin_i       (tdo),
        .q_o         (sreg),
        .sout_o      (sreg_out)
    );

    assign cmd_ready  = (phase_q == PH_RTI) && !rsp_valid_q;
    assign accept     = cmd_valid && cmd_ready;
    assign busy       = (phase_q != PH_RTI);
    assign shift_en   = (phase_q == PH_SHIFT);
    assign tdi        = shift_en ? sreg_out : 1'b0;
    assign last_shift = (cnt_q == len_q - LEN_W'(1));
    assign rsp_valid  = rsp_valid_q;
    assign rsp_data   = rsp_data_q;

    always_comb begin
        len_clamp = cmd_len;
        if (cmd_len == '0) begin
            len_clamp = LEN_W'(1);
        end else if (cmd_len > MAX_LEN_L) begin
            len_clamp = MAX_LEN_L;
        end
    end

    // First-shifted tdo bit sits at [MAX_LEN-len] after len shifts; bring it down to [0].
    always_comb begin
        all_ones = '1;
        aligned  = sreg >> (MAX_LEN - int'(len_q));
        mask     = all_ones >> (MAX_LEN - int'(len_q));
    end

    always_comb begin
        phase_d     = phase_q;
        cnt_d       = cnt_q;
        len_d       = len_q;
        ir_d        = ir_q;
        rst_cmd_d   = rst_cmd_q;
        rsp_valid_d = 1'b0;
        rsp_data_d  = rsp_data_q;
        load        = 1'b0;
        tms         = 1'b0;
        unique case (phase_q)
            PH_TLR: begin
                // TLR_ONES edges of tms=1 force Test-Logic-Reset, the final tms=0 edge lands in RTI.
                tms   = (cnt_q != LEN_W'(TLR_ONES));
                cnt_d = cnt_q + LEN_W'(1);
                if (cnt_q == LEN_W'(TLR_ONES)) begin
                    phase_d     = PH_RTI;
                    cnt_d       = '0;
                    rsp_valid_d = rst_cmd_q;
                    rst_cmd_d   = 1'b0;
                end
            end
            PH_RTI: begin
                if (accept) begin
                    cnt_d = '0;
                    if (cmd_rst) begin
                        phase_d   = PH_TLR;
                        rst_cmd_d = 1'b1;
                    end else begin
                        phase_d = PH_LAUNCH;
                        ir_d    = cmd_ir;
                        len_d   = len_clamp;
                        load    = 1'b1;
                    end
                end
            end
            PH_LAUNCH: begin
                tms     = 1'b1;
                phase_d = PH_SEL_DR;
            end
            PH_SEL_DR: begin
                tms     = ir_q;
                phase_d = ir_q ? PH_SEL_IR : PH_CAP;
            end
            PH_SEL_IR: phase_d = PH_CAP;
            PH_CAP:    phase_d = PH_SHIFT;
            PH_SHIFT: begin
                tms   = last_shift;
                cnt_d = cnt_q + LEN_W'(1);
                if (last_shift) begin
                    phase_d = PH_EXIT1;
                end
            end
            PH_EXIT1: begin
                tms     = 1'b1;
                phase_d = PH_UPD;
            end
            PH_UPD: begin
                phase_d     = PH_RTI;
                rsp_valid_d = 1'b1;
                rsp_data_d  = aligned & mask;
            end
            default: begin
                tms     = 1'b1;
                phase_d = PH_TLR;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge tck or posedge trst) begin
        if (trst) begin
            phase_q     <= PH_TLR;
            cnt_q       <= '0;
            len_q       <= LEN_W'(1);
            ir_q        <= 1'b0;
            rst_cmd_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            phase_q     <= phase_d;
            cnt_q       <= cnt_d;
            len_q       <= len_d;
            ir_q        <= ir_d;
            rst_cmd_q   <= rst_cmd_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

endmodule

// File: tb/tb_jtag_scan_sequencer.sv
// Directed and random scans against a behavioural 1149.1 TAP and per-scan tdo pattern.
module tb_jtag_scan_sequencer;

    localparam int MAX_LEN = 32;
    localparam int LEN_W   = 6;

    typedef enum int {
        T_TLR, T_RTI, T_SELDR, T_CAPDR, T_SHDR, T_EX1DR, T_PADR, T_EX2DR, T_UPDR,
        T_SELIR, T_CAPIR, T_SHIR, T_EX1IR, T_PAIR, T_EX2IR, T_UPIR
    } tap_e;

    logic               tck = 1'b0;
    logic               trst = 1'b1;
    logic               cmd_valid = 1'b0;
    logic               cmd_ready;
    logic               cmd_rst = 1'b0;
    logic               cmd_ir = 1'b0;
    logic [LEN_W-1:0]   cmd_len = '0;
    logic [MAX_LEN-1:0] cmd_data = '0;
    logic               rsp_valid;
    logic [MAX_LEN-1:0] rsp_data;
    logic               busy;
    logic               tms;
    logic               tdi;
    logic               tdo = 1'b0;

    int n_assert = 0;
    int n_fail   = 0;

    jtag_scan_sequencer #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) dut (
        .tck       (tck),
        .trst      (trst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_rst   (cmd_rst),
        .cmd_ir    (cmd_ir),
        .cmd_len   (cmd_len),
        .cmd_data  (cmd_data),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .busy      (busy),
        .tms       (tms),
        .tdi       (tdi),
        .tdo       (tdo)
    );

    always #5 tck = ~tck;

    // TAP model: no trst connection, so only the tms walk can bring it back in sync.
    tap_e        tap_st = T_SHDR;
    logic        tms_s = 1'b1;
    logic        tdi_s = 1'b0;
    int          shift_n = 0;
    int          cap_n = 0;
    int          upd_n = 0;
    int          rsp_pulses = 0;
    bit          sel_ir_seen = 1'b0;
    bit          saw_tlr = 1'b0;
    logic [63:0] tdi_cap = '0;
    logic [31:0] tdo_pat = '0;

    function automatic tap_e tap_next(input tap_e s, input logic m);
        case (s)
            T_TLR:   return m ? T_TLR   : T_RTI;
            T_RTI:   return m ? T_SELDR : T_RTI;
            T_SELDR: return m ? T_SELIR : T_CAPDR;
            T_CAPDR: return m ? T_EX1DR : T_SHDR;
            T_SHDR:  return m ? T_EX1DR : T_SHDR;
            T_EX1DR: return m ? T_UPDR  : T_PADR;
            T_PADR:  return m ? T_EX2DR : T_PADR;
            T_EX2DR: return m ? T_UPDR  : T_SHDR;
            T_UPDR:  return m ? T_SELDR : T_RTI;
            T_SELIR: return m ? T_TLR   : T_CAPIR;
            T_CAPIR: return m ? T_EX1IR : T_SHIR;
            T_SHIR:  return m ? T_EX1IR : T_SHIR;
            T_EX1IR: return m ? T_UPIR  : T_PAIR;
            T_PAIR:  return m ? T_EX2IR : T_PAIR;
            T_EX2IR: return m ? T_UPIR  : T_SHIR;
            T_UPIR:  return m ? T_SELDR : T_RTI;
            default: return T_TLR;
        endcase
    endfunction

    always @(negedge tck) begin
        tms_s = tms;
        tdi_s = tdi;
        if (rsp_valid === 1'b1) rsp_pulses++;
        if ((tap_st == T_SHDR || tap_st == T_SHIR) && shift_n < 32) tdo = tdo_pat[shift_n];
        else tdo = 1'b0;
    end

    always @(posedge tck) begin
        if (tap_st == T_SHDR || tap_st == T_SHIR) begin
            if (shift_n < 64) tdi_cap[shift_n] = tdi_s;
            shift_n++;
        end
        if (tap_st == T_CAPDR || tap_st == T_CAPIR) cap_n++;
        if (tap_st == T_UPDR || tap_st == T_UPIR) upd_n++;
        if (tap_st == T_SELIR) sel_ir_seen = 1'b1;
        tap_st = tap_next(tap_st, tms_s);
        if (tap_st == T_TLR) saw_tlr = 1'b1;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Entered with trst already high; checks reset outputs, releases, then checks the resync walk.
    task automatic trst_and_resync(input string tag);
        int k;
        int rp0;
        logic [7:0] tms_seq;
        #1;
        check({tag, ":rst_tms"}, 64'(tms), 64'(1));
        check({tag, ":rst_tdi"}, 64'(tdi), 64'(0));
        check({tag, ":rst_ready"}, 64'(cmd_ready), 64'(0));
        check({tag, ":rst_busy"}, 64'(busy), 64'(1));
        check({tag, ":rst_rspv"}, 64'(rsp_valid), 64'(0));
        check({tag, ":rst_rspd"}, 64'(rsp_data), 64'(0));
        @(posedge tck);
        @(posedge tck);
        #1 trst = 1'b0;
        rp0 = rsp_pulses;
        saw_tlr = 1'b0;
        tms_seq = '0;
        k = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge tck);
            if (i <= 8) tms_seq[i-1] = tms;
            @(posedge tck);
            #1;
            if (cmd_ready) begin
                k = i;
                break;
            end
        end
        check({tag, ":ready_edges"}, 64'(k), 64'(6));
        check({tag, ":tms_walk"}, 64'(tms_seq), 64'(8'h1F));
        check({tag, ":tap_saw_tlr"}, 64'(saw_tlr), 64'(1));
        check({tag, ":tap_rti"}, 64'(tap_st), 64'(T_RTI));
        repeat (3) @(posedge tck);
        #1;
        check({tag, ":no_rsp"}, 64'(rsp_pulses - rp0), 64'(0));
    endtask

    task automatic run_scan(input string tag, input logic ir, input int len_raw,
                            input logic [31:0] data, input logic [31:0] pat, input bit keep_valid);
        int L;
        int lat;
        int rp0;
        logic [63:0] mask;
        L    = (len_raw == 0) ? 1 : (len_raw > MAX_LEN) ? MAX_LEN : len_raw;
        mask = (64'd1 << L) - 64'd1;
        for (int i = 0; i < 50 && !cmd_ready; i++) begin
            @(posedge tck);
            #1;
        end
        check({tag, ":ready"}, 64'(cmd_ready), 64'(1));
        cmd_valid = 1'b1;
        cmd_rst   = 1'b0;
        cmd_ir    = ir;
        cmd_len   = LEN_W'(len_raw);
        cmd_data  = data;
        tdo_pat   = pat;
        @(posedge tck);
        #1;
        shift_n     = 0;
        tdi_cap     = '0;
        cap_n       = 0;
        upd_n       = 0;
        sel_ir_seen = 1'b0;
        rp0         = rsp_pulses;
        if (!keep_valid) cmd_valid = 1'b0;
        check({tag, ":accepted"}, 64'(busy), 64'(1));
        lat = 0;
        for (int i = 1; i <= 80; i++) begin
            @(posedge tck);
            #1;
            if (rsp_valid) begin
                lat = i;
                break;
            end
        end
        check({tag, ":latency"}, 64'(lat), 64'(L + 5 + int'(ir)));
        check({tag, ":rsp_data"}, 64'(rsp_data), 64'(pat) & mask);
        check({tag, ":shift_cycles"}, 64'(shift_n), 64'(L));
        check({tag, ":tdi_bits"}, tdi_cap, 64'(data) & mask);
        check({tag, ":capture"}, 64'(cap_n), 64'(1));
        check({tag, ":update"}, 64'(upd_n), 64'(1));
        check({tag, ":sel_ir"}, 64'(sel_ir_seen), 64'(ir));
        check({tag, ":ready_in_rsp"}, 64'(cmd_ready), 64'(0));
        check({tag, ":tap_rti"}, 64'(tap_st), 64'(T_RTI));
        @(posedge tck);
        #1;
        check({tag, ":rsp_pulse1"}, 64'(rsp_valid), 64'(0));
        check({tag, ":ready_after"}, 64'(cmd_ready), 64'(1));
        check({tag, ":idle_after"}, 64'(busy), 64'(0));
        check({tag, ":rsp_count"}, 64'(rsp_pulses - rp0), 64'(1));
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int k;
        int rp0;
        logic [7:0] tms_seq;

        // Power-on reset with the TAP model left in Shift-DR.
        #2;
        trst_and_resync("por");

        run_scan("dr8", 1'b0, 8, 32'hA5, 32'h3C, 1'b0);
        run_scan("ir4", 1'b1, 4, 32'h9, $urandom, 1'b0);
        run_scan("len0", 1'b0, 0, $urandom, $urandom, 1'b0);
        run_scan("len40", 1'b1, 40, $urandom, $urandom, 1'b0);
        run_scan("len32", 1'b0, 32, $urandom, $urandom, 1'b0);

        for (int i = 0; i < 6; i++) begin
            run_scan($sformatf("rnd%0d", i), 1'($urandom_range(0, 1)),
                     int'($urandom_range(0, 40)), $urandom, $urandom, 1'b0);
        end

        // Back-to-back with cmd_valid held high throughout.
        run_scan("b2b0", 1'b0, 5, $urandom, $urandom, 1'b1);
        run_scan("b2b1", 1'b1, 3, $urandom, $urandom, 1'b1);
        run_scan("b2b2", 1'b0, 7, $urandom, $urandom, 1'b0);

        // TAP reset command from RTI.
        cmd_valid = 1'b1;
        cmd_rst   = 1'b1;
        @(posedge tck);
        #1;
        cmd_valid = 1'b0;
        cmd_rst   = 1'b0;
        rp0       = rsp_pulses;
        saw_tlr   = 1'b0;
        check("cmdrst:accepted", 64'(busy), 64'(1));
        tms_seq = '0;
        k = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge tck);
            if (i <= 8) tms_seq[i-1] = tms;
            @(posedge tck);
            #1;
            if (rsp_valid) begin
                k = i;
                break;
            end
        end
        check("cmdrst:edges", 64'(k), 64'(6));
        check("cmdrst:tms_walk", 64'(tms_seq), 64'(8'h1F));
        check("cmdrst:saw_tlr", 64'(saw_tlr), 64'(1));
        check("cmdrst:tap_rti", 64'(tap_st), 64'(T_RTI));
        check("cmdrst:ready_in_rsp", 64'(cmd_ready), 64'(0));
        @(posedge tck);
        #1;
        check("cmdrst:ready_after", 64'(cmd_ready), 64'(1));
        check("cmdrst:rsp_count", 64'(rsp_pulses - rp0), 64'(1));

        // trst in the middle of a DR shift.
        cmd_valid = 1'b1;
        cmd_ir    = 1'b0;
        cmd_len   = LEN_W'(20);
        cmd_data  = $urandom;
        tdo_pat   = $urandom;
        @(posedge tck);
        #1;
        cmd_valid = 1'b0;
        repeat (6) @(posedge tck);
        #1;
        check("abort:tap_in_shift", 64'(tap_st), 64'(T_SHDR));
        #2 trst = 1'b1;
        trst_and_resync("abort");

        run_scan("post_abort", 1'b0, 12, $urandom, $urandom, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
